// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock parametrised FIFO with occupancy count, programmable
//   almost-full / almost-empty thresholds, read-data-valid strobe and
//   software-clearable sticky overflow / underflow flags.
//
//   Build option: define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
//   (head entry visible on data_out with zero latency, rd pops it). Without
//   it, data_out is a register loaded one cycle after each accepted read.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   wr, data_in         write request and write data
//   rd                  read request
//   data_out            read data
//   dout_valid          data_out holds newly read data (FWFT: head is valid)
//   fifo_count          occupancy, 0..2**ADDR_W
//   fifo_full/empty     occupancy at depth / at zero
//   af_level, ae_level  almost-full / almost-empty thresholds
//   fifo_almost_full    fifo_count >= af_level
//   fifo_almost_empty   fifo_count <= ae_level
//   err_clr             synchronous clear of the sticky error flags
//   fifo_overflow       sticky: a write was rejected
//   fifo_underflow      sticky: a read was rejected
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  output logic [DATA_W-1:0] data_out,
  output logic              dout_valid,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  input  logic [ADDR_W:0]   af_level,
  input  logic [ADDR_W:0]   ae_level,
  output logic              fifo_almost_full,
  output logic              fifo_almost_empty,
  input  logic              err_clr,
  output logic              fifo_overflow,
  output logic              fifo_underflow
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic              wr_acc;
  logic              rd_acc;

  // Status is derived from the registered pointers only, so acceptance never
  // depends on the same-cycle opposite operation.
  assign fifo_count = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                      (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);

  // Plain unsigned compares already give the threshold corner cases:
  // af_level=0 is always met, af_level>depth never is, ae_level>=depth always is.
  assign fifo_almost_full  = (fifo_count >= af_level);
  assign fifo_almost_empty = (fifo_count <= ae_level);

  assign wr_acc = wr && !fifo_full;
  assign rd_acc = rd && !fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Storage is never reset; a reset only discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr[ADDR_W-1:0]] <= data_in;
  end

  // Sticky errors: a new rejection in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      if (wr && fifo_full)       fifo_overflow <= 1'b1;
      else if (err_clr)          fifo_overflow <= 1'b0;
      if (rd && fifo_empty)      fifo_underflow <= 1'b1;
      else if (err_clr)          fifo_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry falls through; a write to an empty FIFO becomes visible once
  // wptr has advanced, by which time the memory word is already written.
  assign data_out   = mem[rptr[ADDR_W-1:0]];
  assign dout_valid = !fifo_empty;
`else
  // Registered read stage: one cycle of latency, value held between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rptr[ADDR_W-1:0]];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       rd = 1'b0;
  logic [7:0] data_out;
  logic       dout_valid;
  logic [4:0] fifo_count;
  logic       fifo_full;
  logic       fifo_empty;
  logic [4:0] af_level = 5'd16;
  logic [4:0] ae_level = 5'd0;
  logic       fifo_almost_full;
  logic       fifo_almost_empty;
  logic       err_clr = 1'b0;
  logic       fifo_overflow;
  logic       fifo_underflow;

  sync_fifo_param #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .wr                (wr),
    .data_in           (data_in),
    .rd                (rd),
    .data_out          (data_out),
    .dout_valid        (dout_valid),
    .fifo_count        (fifo_count),
    .fifo_full         (fifo_full),
    .fifo_empty        (fifo_empty),
    .af_level          (af_level),
    .ae_level          (ae_level),
    .fifo_almost_full  (fifo_almost_full),
    .fifo_almost_empty (fifo_almost_empty),
    .err_clr           (err_clr),
    .fifo_overflow     (fifo_overflow),
    .fifo_underflow    (fifo_underflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // Scoreboard / reference state
  logic [7:0] mq [$];
  logic       m_ovf  = 1'b0;
  logic       m_udf  = 1'b0;
  logic [7:0] m_last = 8'h00;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic [4:0] af;
    logic [4:0] ae;
    logic [4:0] exp_cnt;
    logic       exp_afl;
    logic       exp_ael;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus with full scoreboard checking after the edge.
  task automatic do_cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    logic       m_full, m_empty, wacc, racc;
    logic [7:0] exp_rd;
    @(negedge clk);
    wr = w; data_in = d; rd = r; err_clr = c;
    m_full  = (mq.size() == 16);
    m_empty = (mq.size() == 0);
    wacc    = w && !m_full;
    racc    = r && !m_empty;
    exp_rd  = m_empty ? 8'h00 : mq[0];
`ifdef SYNC_FIFO_FWFT_EN
    if (racc) chk("fwft_head", {24'h0, data_out}, {24'h0, exp_rd});
`endif
    @(posedge clk);
    #1;
    if (racc) void'(mq.pop_front());
    if (wacc) mq.push_back(d);
    if (w && m_full) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
    if (r && m_empty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    chk("dout_valid", {31'h0, dout_valid}, {31'h0, (mq.size() != 0)});
    if (mq.size() != 0) chk("data_out", {24'h0, data_out}, {24'h0, mq[0]});
`else
    if (racc) m_last = exp_rd;
    chk("data_out", {24'h0, data_out}, {24'h0, m_last});
    chk("dout_valid", {31'h0, dout_valid}, {31'h0, racc});
`endif
    chk("count", {27'h0, fifo_count}, mq.size());
    chk("full", {31'h0, fifo_full}, {31'h0, (mq.size() == 16)});
    chk("empty", {31'h0, fifo_empty}, {31'h0, (mq.size() == 0)});
    chk("overflow", {31'h0, fifo_overflow}, {31'h0, m_ovf});
    chk("underflow", {31'h0, fifo_underflow}, {31'h0, m_udf});
    wr = 1'b0; rd = 1'b0; err_clr = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_count", {27'h0, fifo_count}, 32'd0);
    chk("rst_empty", {31'h0, fifo_empty}, 32'd1);
    chk("rst_full", {31'h0, fifo_full}, 32'd0);
    chk("rst_ovf", {31'h0, fifo_overflow}, 32'd0);
    chk("rst_udf", {31'h0, fifo_underflow}, 32'd0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", {24'h0, data_out}, 32'd0);
`endif
    chk("rst_dvalid", {31'h0, dout_valid}, 32'd0);
  endtask

  initial begin
    // Threshold table: fill 0..16 with af=12, ae=3, then corner thresholds at count 16
    tbl[0] = '{1'b0, 8'h00, 5'd12, 5'd3, 5'd0, 1'b0, 1'b1};
    for (int i = 1; i <= 16; i++)
      tbl[i] = '{1'b1, 8'(8'h30 + i), 5'd12, 5'd3, 5'(i), (i >= 12), (i <= 3)};
    tbl[17] = '{1'b0, 8'h00, 5'd0,  5'd3,  5'd16, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 8'h00, 5'd17, 5'd3,  5'd16, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 8'h00, 5'd16, 5'd16, 5'd16, 1'b1, 1'b1};
    tbl[20] = '{1'b0, 8'h00, 5'd16, 5'd15, 5'd16, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 8'h00, 5'd31, 5'd31, 5'd16, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0;

    // 1: write 0x01..0x10, read 16
    for (int i = 1; i <= 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    chk("t1_full", {31'h0, fifo_full}, 32'd1);
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_empty", {31'h0, fifo_empty}, 32'd1);

    // 2: overflow, drain, clear
    for (int i = 1; i <= 16; i++) do_cycle(1'b1, 8'(i), 1'b0, 1'b0);
    do_cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t2_ovf", {31'h0, fifo_overflow}, 32'd1);
    do_cycle(1'b1, 8'hAB, 1'b1, 1'b0);   // full + wr + rd: read taken, write rejected
    for (int i = 0; i < 15; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_ovf_clr", {31'h0, fifo_overflow}, 32'd0);

    // 3: empty with simultaneous wr/rd, then set-wins-over-clear
    do_cycle(1'b1, 8'h55, 1'b1, 1'b0);
    chk("t3_udf", {31'h0, fifo_underflow}, 32'd1);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t3_setwins", {31'h0, fifo_underflow}, 32'd1);
    do_cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // 4: threshold table
    for (int i = 0; i < 22; i++) begin
      af_level = tbl[i].af;
      ae_level = tbl[i].ae;
      do_cycle(tbl[i].w, tbl[i].d, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_cnt", i), {27'h0, fifo_count}, {27'h0, tbl[i].exp_cnt});
      chk($sformatf("tbl%0d_afl", i), {31'h0, fifo_almost_full}, {31'h0, tbl[i].exp_afl});
      chk($sformatf("tbl%0d_ael", i), {31'h0, fifo_almost_empty}, {31'h0, tbl[i].exp_ael});
    end
    af_level = 5'd16;
    ae_level = 5'd0;
    for (int i = 0; i < 16; i++) do_cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: hold count at 8 while streaming, pointers wrap several times
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
      chk("t5_cnt8", {27'h0, fifo_count}, 32'd8);
    end

    // 6: asynchronous reset mid-burst at count 9
    do_cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("t6_cnt9", {27'h0, fifo_count}, 32'd9);
    @(negedge clk);
    wr = 1'b1; data_in = 8'hEE; rd = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_reset_state();
    @(posedge clk);
    #1;
    chk_reset_state();
    @(negedge clk);
    rst = 1'b0; wr = 1'b0; rd = 1'b0;
    mq.delete();
    m_ovf = 1'b0; m_udf = 1'b0; m_last = 8'h00;
    do_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    do_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_empty", {31'h0, fifo_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, parametrised-width/depth synchronous FIFO. Next generation of the team's 8x16 FIFO memory unit.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a read-data-valid strobe, and software-clearable sticky error flags.
- Sits between a producer and consumer in the same clock domain as the standard buffering primitive for datapath blocks.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- ADDR_W, 4, address width; depth = 2**ADDR_W entries (ADDR_W >= 2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr  in  1  write request.
- data_in  in  DATA_W  write data, sampled when a write is accepted.
- rd  in  1  read request.
- data_out  out  DATA_W  read data.
- dout_valid  out  1  data_out holds newly read data (see Behaviour).
- fifo_count  out  ADDR_W+1  current occupancy, 0..2**ADDR_W.
- fifo_full  out  1  count == 2**ADDR_W.
- fifo_empty  out  1  count == 0.
- af_level  in  ADDR_W+1  almost-full threshold.
- ae_level  in  ADDR_W+1  almost-empty threshold.
- fifo_almost_full  out  1  count >= af_level.
- fifo_almost_empty  out  1  count <= ae_level.
- err_clr  in  1  synchronous clear of the sticky error flags.
- fifo_overflow  out  1  sticky: a write was rejected.
- fifo_underflow  out  1  sticky: a read was rejected.

Behaviour:
- Pointers:
  - wptr and rptr are ADDR_W+1 bits. The low ADDR_W bits address the storage; the MSB is the wrap bit.
  - Both pointers increment modulo 2**(ADDR_W+1) when their operation is accepted.
- Acceptance:
  - A write is accepted iff wr && !fifo_full.
  - A read is accepted iff rd && !fifo_empty.
  - Acceptance uses flags from the current registered pointers, not from same-cycle operations.
- Status:
  - fifo_count = wptr - rptr, modulo 2**(ADDR_W+1).
  - fifo_full = (MSBs differ) && (low bits equal).
  - fifo_empty = (pointers equal).
  - Almost flags are unsigned compares against fifo_count.
  - All status outputs are combinational from registered pointers and threshold inputs only; there is no path from wr/rd.
- Simultaneous wr and rd:
  - When neither full nor empty, both are accepted and the count is unchanged.
  - When full, the read is accepted, the write is rejected, and overflow is set.
  - When empty, the write is accepted, the read is rejected, and underflow is set.
- Storage: an accepted write stores data_in at wptr[ADDR_W-1:0] on the same edge.
- Read path (default):
  - data_out is registered and loaded from rptr[ADDR_W-1:0] on the edge that accepts a read.
  - Latency is 1 cycle; data_out holds its value otherwise.
  - dout_valid is a 1-cycle pulse in the cycle after each accepted read.
- Error flags:
  - fifo_overflow sets on the edge after a rejected write; fifo_underflow sets on the edge after a rejected read.
  - Both hold until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, set wins.
- Threshold edge cases:
  - af_level = 0 forces almost_full = 1.
  - af_level > depth forces almost_full = 0.
  - ae_level >= depth forces almost_empty = 1.
  - Thresholds may change at any time; the flags follow combinationally.
- Reset values:
  - wptr and rptr = 0.
  - data_out = 0, dout_valid = 0, fifo_overflow = 0, fifo_underflow = 0.
  - Derived: fifo_empty = 1, fifo_full = 0, fifo_count = 0.
- Reset mid-operation:
  - All contents are logically discarded immediately and asynchronously.
  - Storage RAM is not cleared.
  - Requests on the first edge after rst deasserts are evaluated against the empty state.
- Wrap-around: correct across any number of pointer wraps; no state depends on absolute pointer value.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out shows the head entry with zero latency; rd pops it.
  - dout_valid = !fifo_empty, combinational.
  - After a write into an empty FIFO, data_out is valid on the next cycle.
  - Write-to-read on the same entry must not return stale data.
- Undefined: the registered 1-cycle-latency read path above. The FWFT logic is not synthesised.

Test Plan (DATA_W=8, ADDR_W=4):
1. Reset, then write 0x01..0x10 over 16 cycles, then read 16.
   - Required: fifo_full=1 and count=16 after the 16th write.
   - Required: data_out sequence 0x01..0x10, each with a dout_valid pulse 1 cycle after its rd.
   - Required: fifo_empty=1 at the end.
2. Fill to 16, then wr=1 with data 0xAA.
   - Required: fifo_overflow=1 next cycle and count stays 16.
   - Required: draining returns 0x01..0x10 with no 0xAA.
   - Required: err_clr pulse returns fifo_overflow to 0.
3. Empty FIFO with wr=1, rd=1, data 0x55.
   - Required: fifo_underflow=1, count=1.
   - Required: the next read returns 0x55.
4. Set af_level=12, ae_level=3 and fill one word at a time.
   - Required: almost_empty=1 for count 0..3, 0 from 4.
   - Required: almost_full=0 up to count 11, 1 from 12.
5. Hold count at 8 while streaming simultaneous wr/rd for 40 cycles (pointers wrap at least twice).
   - Required: count constant at 8 and data order preserved.
6. Assert rst asynchronously mid-burst at count=9.
   - Required: count=0, empty=1, flags=0 immediately.
   - Required: after release, a write of 0x77 then a read returns 0x77.
   - With SYNC_FIFO_FWFT_EN defined: 0x77 appears on data_out 1 cycle after the write, before rd.
